// File: rtl/fix_tx_scheduler_if.sv
// Requester/grant and header-encoder handshake bundle for the FIX transmit scheduler.
// The scheduler takes the master modport; the encoders side takes the slave modport.
interface fix_tx_scheduler_if #(
    parameter int FIX_PAYLOAD_LEN = 220,
    parameter int NUM_REQ         = 6,
    parameter int SEQ_W           = 32
);
    logic [NUM_REQ-1:0]                   req;
    logic [NUM_REQ*FIX_PAYLOAD_LEN*8-1:0] req_payload;
    logic [NUM_REQ-1:0]                   grant_ack;
    logic                                 enc_valid;
    logic                                 enc_ready;
    logic [FIX_PAYLOAD_LEN*8-1:0]         enc_payload;
    logic [SEQ_W-1:0]                     enc_seq_num;
    logic [2:0]                           enc_src;

    modport master (
        input  req, req_payload, enc_ready,
        output grant_ack, enc_valid, enc_payload, enc_seq_num, enc_src
    );

    modport slave (
        output req, req_payload, enc_ready,
        input  grant_ack, enc_valid, enc_payload, enc_seq_num, enc_src
    );
endinterface

// File: rtl/fix_tx_scheduler.sv
// FIX transmit scheduler: fixed-priority arbitration for the header encoder,
// MsgSeqNum assignment and the heartbeat interval timer.
module fix_tx_scheduler #(
    parameter int FIX_PAYLOAD_LEN = 220,
    parameter int NUM_REQ         = 6,
    parameter int SEQ_W           = 32,
    parameter int HB_INTERVAL     = 10000000
) (
    input  logic                     clk,
    input  logic                     rst,
    fix_tx_scheduler_if.master       bus,
    input  logic [SEQ_W-1:0]         resend_seq,
    input  logic                     session_active,
    input  logic                     hb_enable,
    output logic [SEQ_W-1:0]         next_seq,
    output logic                     hb_due,
    output logic                     busy
);
    localparam int PW   = FIX_PAYLOAD_LEN * 8;
    localparam int HB_W = $clog2(HB_INTERVAL + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0]       RESEND_SRC = 3'd3;
    localparam logic [SEQ_W-1:0] SEQ_MAX    = '1;
    localparam logic [SEQ_W-1:0] SEQ_FIRST  = SEQ_W'(1);
    localparam logic [HB_W-1:0]  HB_MAX     = HB_W'(HB_INTERVAL);

    logic [1:0]         state;
    logic [NUM_REQ-1:0] eligible;
    logic               any_eligible;
    logic [2:0]         winner;
    logic [PW-1:0]      payload_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [2:0]         src_q;
    logic [HB_W-1:0]    hb_cnt;
    logic [NUM_REQ-1:0] grant;

    // Order traffic is held back until logon completes; highest index wins.
    always_comb begin
        eligible = bus.req;
        if (!session_active) begin
            eligible[0] = 1'b0;
        end
        any_eligible = |eligible;
        winner       = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            payload_q <= '0;
            seq_q     <= '0;
            src_q     <= '0;
            next_seq  <= SEQ_FIRST;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_eligible) begin
                        payload_q <= bus.req_payload[int'(winner)*PW +: PW];
                        src_q     <= winner;
                        seq_q     <= (winner == RESEND_SRC) ? resend_seq : next_seq;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.enc_ready) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Resend replies reuse an old number; 0 is skipped on wrap.
                    if (src_q != RESEND_SRC) begin
                        next_seq <= (next_seq == SEQ_MAX) ? SEQ_FIRST : next_seq + 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Any outgoing message counts as link activity and restarts the interval.
    always_ff @(posedge clk) begin
        if (rst || state == S_DONE || !hb_enable) begin
            hb_cnt <= '0;
        end else if (hb_cnt != HB_MAX) begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    always_comb begin
        grant = '0;
        if (state == S_DONE) begin
            grant[src_q] = 1'b1;
        end
    end

    assign bus.grant_ack   = grant;
    assign bus.enc_valid   = (state == S_ISSUE);
    assign bus.enc_payload = payload_q;
    assign bus.enc_seq_num = seq_q;
    assign bus.enc_src     = src_q;
    assign hb_due          = (hb_cnt == HB_MAX);
    assign busy            = (state != S_IDLE);
endmodule

// File: tb/tb_fix_tx_scheduler.sv
// Randomized self-checking bench for fix_tx_scheduler against a transaction-level model
// of message lifecycle, sequence numbering and heartbeat timing.
module tb_fix_tx_scheduler;
    localparam int PL      = 4;
    localparam int NR      = 6;
    localparam int SW      = 4;
    localparam int HB      = 16;
    localparam int PW      = PL * 8;
    localparam int SEQ_MOD = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] resend_seq;
    logic          session_active;
    logic          hb_enable;
    logic [SW-1:0] next_seq;
    logic          hb_due;
    logic          busy;

    logic [NR-1:0] req_v;
    logic [PW-1:0] pay [NR];

    int tests    = 0;
    int failures = 0;

    // Reference model: one in-flight message that is offered, accepted, then acknowledged.
    bit            m_busy;
    bit            m_acked;
    int            m_src;
    logic [SW-1:0] m_seq;
    logic [PW-1:0] m_pay;
    int            m_next;
    int            m_hb;

    fix_tx_scheduler_if #(.FIX_PAYLOAD_LEN(PL), .NUM_REQ(NR), .SEQ_W(SW)) bus ();

    fix_tx_scheduler #(
        .FIX_PAYLOAD_LEN(PL),
        .NUM_REQ(NR),
        .SEQ_W(SW),
        .HB_INTERVAL(HB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .resend_seq(resend_seq),
        .session_active(session_active),
        .hb_enable(hb_enable),
        .next_seq(next_seq),
        .hb_due(hb_due),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign bus.req = req_v;
    always_comb begin
        bus.req_payload = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_payload[i*PW +: PW] = pay[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkCycle();
        logic [NR-1:0] exp_grant;
        exp_grant = '0;
        if (m_acked) exp_grant[m_src] = 1'b1;
        checkOutput("enc_valid",   64'(bus.enc_valid),   64'(m_busy && !m_acked));
        checkOutput("grant_ack",   64'(bus.grant_ack),   64'(exp_grant));
        checkOutput("busy",        64'(busy),            64'(m_busy));
        checkOutput("next_seq",    64'(next_seq),        64'(m_next));
        checkOutput("hb_due",      64'(hb_due),          64'(m_hb == HB));
        checkOutput("enc_payload", 64'(bus.enc_payload), 64'(m_pay));
        checkOutput("enc_seq_num", 64'(bus.enc_seq_num), 64'(m_seq));
        checkOutput("enc_src",     64'(bus.enc_src),     64'(m_src));
    endtask

    task automatic modelStep();
        int pick;
        if (rst) begin
            m_busy = 0; m_acked = 0; m_src = 0; m_seq = '0; m_pay = '0;
            m_next = 1; m_hb = 0;
            return;
        end
        if (m_acked) begin
            if (m_src != 3) m_next = (m_next % SEQ_MOD) + 1;
            m_busy  = 0;
            m_acked = 0;
            m_hb    = 0;
            return;
        end
        m_hb = hb_enable ? ((m_hb < HB) ? m_hb + 1 : HB) : 0;
        if (m_busy) begin
            if (bus.enc_ready) m_acked = 1;
        end else begin
            pick = -1;
            for (int i = 0; i < NR; i++) begin
                if (req_v[i] && (i != 0 || session_active)) pick = i;
            end
            if (pick >= 0) begin
                m_busy = 1;
                m_src  = pick;
                m_pay  = pay[pick];
                m_seq  = (pick == 3) ? resend_seq : SW'(m_next);
            end
        end
    endtask

    // Called just after a falling edge: requester behaviour, model advance, then check.
    task automatic applyStimulus(input logic [NR-1:0] raise);
        if (m_acked) req_v[m_src] = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (raise[i] && !req_v[i]) begin
                pay[i]   = PW'($urandom);
                req_v[i] = 1'b1;
            end
        end
        modelStep();
        @(negedge clk);
        checkCycle();
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus('0);
    endtask

    initial begin
        rst            = 1'b1;
        req_v          = '0;
        resend_seq     = '0;
        session_active = 1'b0;
        hb_enable      = 1'b0;
        bus.enc_ready  = 1'b0;
        for (int i = 0; i < NR; i++) pay[i] = '0;
        m_busy = 0; m_acked = 0; m_src = 0; m_seq = '0; m_pay = '0; m_next = 1; m_hb = 0;

        @(negedge clk);
        idleCycles(3);
        rst = 1'b0;

        // Order request is masked until the session is up.
        bus.enc_ready = 1'b1;
        applyStimulus(6'b000001);
        idleCycles(20);
        session_active = 1'b1;
        idleCycles(4);

        // Simultaneous requests served in priority order.
        applyStimulus(6'b100101);
        idleCycles(12);

        // Resend reply reuses the supplied number without consuming one.
        resend_seq = SW'(7);
        applyStimulus(6'b001000);
        idleCycles(3);
        applyStimulus(6'b000001);
        idleCycles(3);

        // Encoder stall with the request withdrawn mid-flight.
        bus.enc_ready = 1'b0;
        applyStimulus(6'b000001);
        applyStimulus('0);
        req_v[0] = 1'b0;
        idleCycles(10);
        bus.enc_ready = 1'b1;
        idleCycles(3);

        // Heartbeat interval expiry and restart after a heartbeat is sent.
        hb_enable = 1'b1;
        idleCycles(20);
        applyStimulus(6'b000010);
        idleCycles(6);

        // Sequence wrap past the largest value.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(6'b000001);
            idleCycles(2);
        end

        // Reset while a message is being offered.
        bus.enc_ready = 1'b0;
        applyStimulus(6'b010000);
        applyStimulus('0);
        req_v = '0;
        rst   = 1'b1;
        applyStimulus('0);
        rst   = 1'b0;
        bus.enc_ready = 1'b1;
        idleCycles(4);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [NR-1:0] raise;
            rst           = ($urandom_range(0, 299) == 0);
            bus.enc_ready = ($urandom_range(0, 3) != 0);
            hb_enable     = ($urandom_range(0, 99) != 0);
            resend_seq    = SW'($urandom);
            if ($urandom_range(0, 49) == 0) session_active = ~session_active;
            raise = '0;
            for (int i = 0; i < NR; i++) raise[i] = ($urandom_range(0, 15) == 0);
            applyStimulus(raise);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
